// File: rtl/spi_frame_slave.sv
// SPI slave with clk-domain oversampling of SCK/SSEL/MOSI, fixed-width TX frame and RX words.
// Optional frame-length error reporting is enabled by defining SPI_FRAME_ERR_EN.
module spi_frame_slave #(
   parameter int unsigned RX_W = 16,
   parameter int unsigned TX_W = 40,
   parameter int unsigned CPOL = 0,
   parameter int unsigned CPHA = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            SCK,
   input  logic            SSEL,
   input  logic            MOSI,
   output logic            MISO,
   input  logic [TX_W-1:0] tx_data,
   output logic [RX_W-1:0] rx_data,
   output logic            rx_valid,
   output logic            busy,
   output logic            frame_err,
   output logic [7:0]      err_cnt
);

   localparam int unsigned CNT_W    = (RX_W > 2) ? $clog2(RX_W) : 1;
   localparam logic        SCK_IDLE = (CPOL != 0);
   localparam logic        CPHA_ONE = (CPHA != 0);

   logic [2:0]      r_sck_sync;
   logic [2:0]      r_ssel_sync;
   logic [1:0]      r_mosi_sync;
   logic [TX_W-1:0] r_tx_shift;
   logic [RX_W-1:0] r_rx_shift;
   logic [RX_W-1:0] r_rx_data;
   logic [CNT_W-1:0] r_bit_cnt;
   logic            r_first_edge;
   logic            r_rx_valid;

   logic            w_sck_rise, w_sck_fall, w_lead, w_trail;
   logic            w_ssel_fall, w_active, w_sample, w_shift, w_word_done;
   logic [RX_W-1:0] w_rx_next;
   logic [CNT_W-1:0] w_cnt_next;

   // Stage 1 is the newest synchronised value, stage 2 the one before it.
   assign w_sck_rise  = (r_sck_sync[2:1] == 2'b01);
   assign w_sck_fall  = (r_sck_sync[2:1] == 2'b10);
   assign w_ssel_fall = (r_ssel_sync[2:1] == 2'b10);
   // Keyed on the older stage so a sample edge coinciding with frame end still counts.
   assign w_active    = ~r_ssel_sync[2];

   assign w_lead      = SCK_IDLE ? w_sck_fall : w_sck_rise;
   assign w_trail     = SCK_IDLE ? w_sck_rise : w_sck_fall;
   assign w_sample    = w_active & (CPHA_ONE ? w_trail : w_lead);
   assign w_shift     = w_active & (CPHA_ONE ? w_lead : w_trail);

   assign w_word_done = w_sample & (r_bit_cnt == CNT_W'(RX_W - 1));
   assign w_rx_next   = {r_rx_shift[RX_W-2:0], r_mosi_sync[1]};

   always_comb begin
      w_cnt_next = r_bit_cnt;
      if (w_sample) begin
         w_cnt_next = w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sck_sync   <= {3{SCK_IDLE}};
         r_ssel_sync  <= 3'b111;
         r_mosi_sync  <= 2'b00;
         r_tx_shift   <= '0;
         r_rx_shift   <= '0;
         r_rx_data    <= '0;
         r_bit_cnt    <= '0;
         r_first_edge <= 1'b0;
         r_rx_valid   <= 1'b0;
      end else begin
         r_sck_sync  <= {r_sck_sync[1:0], SCK};
         r_ssel_sync <= {r_ssel_sync[1:0], SSEL};
         r_mosi_sync <= {r_mosi_sync[0], MOSI};
         r_rx_valid  <= w_word_done;
         if (w_ssel_fall) begin
            r_tx_shift   <= tx_data;
            r_rx_shift   <= '0;
            r_bit_cnt    <= '0;
            r_first_edge <= 1'b1;
         end else begin
            if (w_sample) begin
               r_rx_shift <= w_rx_next;
               r_bit_cnt  <= w_cnt_next;
               if (w_word_done) begin
                  r_rx_data <= w_rx_next;
               end
            end
            if (w_shift) begin
               r_first_edge <= 1'b0;
               // In CPHA=1 the first leading edge only arms shifting; the MSB is already out.
               if (!(CPHA_ONE && r_first_edge)) begin
                  r_tx_shift <= {r_tx_shift[TX_W-2:0], 1'b0};
               end
            end
         end
      end
   end

   assign busy     = ~r_ssel_sync[1];
   assign MISO     = busy & r_tx_shift[TX_W-1];
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

`ifdef SPI_FRAME_ERR_EN
   logic       r_frame_err;
   logic [7:0] r_err_cnt;
   logic       w_ssel_rise, w_bad_end;

   assign w_ssel_rise = (r_ssel_sync[2:1] == 2'b01);
   assign w_bad_end   = w_ssel_rise & (w_cnt_next != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_err <= 1'b0;
         r_err_cnt   <= 8'd0;
      end else begin
         r_frame_err <= w_bad_end;
         if (w_bad_end && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign frame_err = r_frame_err;
   assign err_cnt   = r_err_cnt;
`else
   assign frame_err = 1'b0;
   assign err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: a mode-0 default instance and a mode-3, 8-bit-word instance share
// one SCK/MOSI bus; received words are checked through per-instance scoreboards.
module tb_spi_frame_slave;

   localparam int H = 8;
`ifdef SPI_FRAME_ERR_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SCK = 1'b0;
   logic        MOSI = 1'b0;
   logic        ssel0 = 1'b1;
   logic        ssel3 = 1'b1;
   logic [39:0] tx0 = '0;
   logic [15:0] tx3 = '0;

   logic        miso0, miso3, rx_valid0, rx_valid3, busy0, busy3, ferr0, ferr3;
   logic [15:0] rx_data0;
   logic [7:0]  rx_data3;
   logic [7:0]  errcnt0, errcnt3;

   always #5 clk = ~clk;

   spi_frame_slave u_dut0 (
      .clk(clk), .rst_n(rst_n), .SCK(SCK), .SSEL(ssel0), .MOSI(MOSI), .MISO(miso0),
      .tx_data(tx0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0),
      .frame_err(ferr0), .err_cnt(errcnt0)
   );

   spi_frame_slave #(.RX_W(8), .TX_W(16), .CPOL(1), .CPHA(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .SCK(SCK), .SSEL(ssel3), .MOSI(MOSI), .MISO(miso3),
      .tx_data(tx3), .rx_data(rx_data3), .rx_valid(rx_valid3), .busy(busy3),
      .frame_err(ferr3), .err_cnt(errcnt3)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] q0[$];
   logic [63:0] q3[$];
   int          ferr0_seen = 0;
   int          ferr3_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid0) begin
            if (q0.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rx_valid0_unexpected: got word %0h, required no word", rx_data0);
            end else begin
               chk("rx_word0", 64'(rx_data0), q0.pop_front());
            end
         end
         if (rx_valid3) begin
            if (q3.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rx_valid3_unexpected: got word %0h, required no word", rx_data3);
            end else begin
               chk("rx_word3", 64'(rx_data3), q3.pop_front());
            end
         end
         if (ferr0) ferr0_seen++;
         if (ferr3) ferr3_seen++;
      end
   end

   // end_mode: 0 = normal deselect, 1 = stay selected, 2 = deselect with the last sample edge.
   task automatic xfer(input int dut, input logic [63:0] data, input int nbits,
                       input int end_mode, output logic [63:0] cap);
      logic cpol, b;
      cpol = (dut == 3);
      cap  = '0;
      SCK  = cpol;
      wclk(H);
      if (dut == 3) ssel3 = 1'b0;
      else ssel0 = 1'b0;
      wclk(H);
      chk((dut == 3) ? "busy3" : "busy0", 64'((dut == 3) ? busy3 : busy0), 64'd1);
      for (int i = 0; i < nbits; i++) begin
         b = data[nbits-1-i];
         if (!cpol) begin
            MOSI = b;
            wclk(H);
            cap = {cap[62:0], miso0};
            SCK = 1'b1;
            if (end_mode == 2 && i == nbits - 1) ssel0 = 1'b1;
            wclk(H);
            SCK = 1'b0;
         end else begin
            SCK  = 1'b0;
            MOSI = b;
            wclk(H);
            cap = {cap[62:0], miso3};
            SCK = 1'b1;
            wclk(H);
         end
      end
      wclk(H);
      if (end_mode == 0) begin
         ssel0 = 1'b1;
         ssel3 = 1'b1;
         wclk(2 * H);
      end else if (end_mode == 2) begin
         wclk(H);
      end
   endtask

   typedef struct {
      int          dut;
      logic [63:0] tx;
      logic [63:0] mosi;
      int          nbits;
      logic [63:0] exp_miso;
   } vec_t;

   vec_t        vt[6];
   logic [63:0] cap;
   logic [63:0] last0, last3, mask, word;
   int          e0, e3, f0, f3, rxw, nfr;
   logic        any_miso, bad;

   initial begin
      vt[0] = '{0, 64'h12_3456_789A, 64'hA55A, 16, 64'h1234};
      vt[1] = '{0, 64'h80_0000_0001, 64'h1111_2222_3333, 48, 64'h8000_0000_0100};
      vt[2] = '{0, 64'hC3_0F00_0000, 64'hDEAD_BEEF, 32, 64'hC30F_0000};
      vt[3] = '{3, 64'hA5C3, 64'h3CC3, 16, 64'hA5C3};
      vt[4] = '{3, 64'h0001, 64'h01_80FF, 24, 64'h00_0100};
      vt[5] = '{0, 64'hF0_0000_0000, 64'h1ABC, 13, 64'h1E00};

      // Reset state
      wclk(4);
      rst_n = 1'b1;
      wclk(4);
      chk("rst_rx_valid0", 64'(rx_valid0), 64'd0);
      chk("rst_rx_data0", 64'(rx_data0), 64'd0);
      chk("rst_busy0", 64'(busy0), 64'd0);
      chk("rst_miso0", 64'(miso0), 64'd0);
      chk("rst_ferr0", 64'(ferr0), 64'd0);
      chk("rst_errcnt0", 64'(errcnt0), 64'd0);
      chk("rst_rx_data3", 64'(rx_data3), 64'd0);
      chk("rst_busy3", 64'(busy3), 64'd0);

      // SCK activity while deselected is ignored
      tx0 = 40'hFF_FFFF_FFFF;
      tx3 = 16'hFFFF;
      any_miso = 1'b0;
      for (int i = 0; i < 20; i++) begin
         SCK  = ~SCK;
         MOSI = 1'($urandom_range(1));
         wclk(4);
         any_miso = any_miso | miso0 | miso3;
      end
      SCK = 1'b0;
      wclk(H);
      chk("idle_miso", 64'(any_miso), 64'd0);
      chk("idle_rx_data0", 64'(rx_data0), 64'd0);

      // Last sample edge and frame end land in the same cycle
      f0 = ferr0_seen;
      q0.push_back(64'h5A5A);
      xfer(0, 64'h5A5A, 16, 2, cap);
      chk("coinc_sb0", 64'(q0.size()), 64'd0);
      chk("coinc_rx_data0", 64'(rx_data0), 64'h5A5A);
      chk("coinc_ferr0", 64'(ferr0_seen - f0), 64'd0);
      chk("coinc_errcnt0", 64'(errcnt0), 64'd0);

      // Reset after bit 7 aborts the frame; a fresh frame then works
      xfer(0, 64'hAB, 8, 1, cap);
      rst_n = 1'b0;
      ssel0 = 1'b1;
      SCK   = 1'b0;
      wclk(3);
      rst_n = 1'b1;
      wclk(4);
      chk("midrst_rx_data0", 64'(rx_data0), 64'd0);
      chk("midrst_busy0", 64'(busy0), 64'd0);
      chk("midrst_miso0", 64'(miso0), 64'd0);
      q0.push_back(64'hBEEF);
      xfer(0, 64'hBEEF, 16, 0, cap);
      chk("midrst_sb0", 64'(q0.size()), 64'd0);
      chk("midrst_beef", 64'(rx_data0), 64'hBEEF);

      // Table-driven frames
      last0 = 64'hBEEF;
      last3 = 64'h0;
      e0 = 0;
      e3 = 0;
      for (int v = 0; v < 6; v++) begin
         rxw  = (vt[v].dut == 3) ? 8 : 16;
         mask = (64'd1 << rxw) - 64'd1;
         for (int w = 0; w < vt[v].nbits / rxw; w++) begin
            word = (vt[v].mosi >> (vt[v].nbits - (w + 1) * rxw)) & mask;
            if (vt[v].dut == 3) begin
               q3.push_back(word);
               last3 = word;
            end else begin
               q0.push_back(word);
               last0 = word;
            end
         end
         bad = ErrEn && ((vt[v].nbits % rxw) != 0);
         f0  = ferr0_seen;
         f3  = ferr3_seen;
         if (vt[v].dut == 3) tx3 = vt[v].tx[15:0];
         else tx0 = vt[v].tx[39:0];
         xfer(vt[v].dut, vt[v].mosi, vt[v].nbits, 0, cap);
         chk($sformatf("v%0d_miso", v), cap, vt[v].exp_miso);
         if (vt[v].dut == 3) begin
            if (bad && e3 < 255) e3++;
            chk($sformatf("v%0d_sb3", v), 64'(q3.size()), 64'd0);
            chk($sformatf("v%0d_rx_data3", v), 64'(rx_data3), last3);
            chk($sformatf("v%0d_ferr3", v), 64'(ferr3_seen - f3), 64'(bad));
            chk($sformatf("v%0d_errcnt3", v), 64'(errcnt3), 64'(e3));
         end else begin
            if (bad && e0 < 255) e0++;
            chk($sformatf("v%0d_sb0", v), 64'(q0.size()), 64'd0);
            chk($sformatf("v%0d_rx_data0", v), 64'(rx_data0), last0);
            chk($sformatf("v%0d_ferr0", v), 64'(ferr0_seen - f0), 64'(bad));
            chk($sformatf("v%0d_errcnt0", v), 64'(errcnt0), 64'(e0));
         end
      end

      // Repeated short frames: error counter saturation
      tx0 = '0;
      nfr = ErrEn ? 300 : 3;
      f0  = ferr0_seen;
      for (int k = 0; k < nfr; k++) begin
         xfer(0, 64'h1, 1, 0, cap);
      end
      if (ErrEn) e0 = (e0 + nfr > 255) ? 255 : e0 + nfr;
      chk("sat_errcnt0", 64'(errcnt0), 64'(e0));
      chk("sat_ferr0", 64'(ferr0_seen - f0), ErrEn ? 64'(nfr) : 64'd0);
      chk("sat_rx_data0", 64'(rx_data0), last0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
